piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the 4-bit serial-in/serial-out shift-register stage.
- Accepts an N-bit word over a valid/ready handshake and emits it one bit per clk on s_out, with s_out driving the downstream stage's s_in.
- Provides framing status (s_valid, busy, done).
- Back-to-back words stream with no idle bit between them.

Parameters:
- N, 4: word width in bits; legal range 2..32.
- MSB_FIRST, 0: bit order on s_out. 0 = bit 0 first (LSB-first, matching the downstream right-shift direction); 1 = bit N-1 first.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- p_in  input  N  parallel word; sampled only on an accept cycle
- load_valid  input  1  producer has a word on p_in
- load_ready  output  1  block can accept a word this cycle
- s_out  output  1  serial data bit; registered
- s_valid  output  1  s_out carries a payload (or parity) bit this cycle
- busy  output  1  a frame is in progress (state SHIFT)
- done  output  1  one-cycle pulse coincident with the last bit of a frame

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. All state is updated on the rising edge of clk.
- Reset values: state = IDLE, shift register = 0, bit counter = 0, s_out = 0, s_valid = 0, busy = 0, done = 0. load_ready = 1 once reset deasserts.
- Accept: an accept occurs on any cycle where load_valid && load_ready at the rising edge.
- Registers:
  - shreg, N bits (N+1 with parity).
  - cnt, width clog2(N+1).
  - state: IDLE or SHIFT.
- IDLE:
  - load_ready = 1, s_valid = 0, s_out = 0, busy = 0.
  - On accept: shreg <= p_in; cnt <= N-1 (N with parity); state -> SHIFT.
- SHIFT:
  - s_valid = 1, busy = 1.
  - s_out = shreg[0] when LSB-first, or shreg[N-1] when MSB-first.
  - Each cycle shreg shifts one position toward the output end, filling with 0, and cnt decrements.
- Last bit (cnt == 0 in SHIFT):
  - done = 1 and load_ready = 1.
  - With an accept on the same edge: reload shreg and cnt, stay in SHIFT. The first bit of the new word follows the last bit of the old word with no gap.
  - Without an accept: state -> IDLE; s_out returns to 0 on the next cycle.
- Not last bit (cnt != 0 in SHIFT): load_ready = 0. p_in and load_valid are ignored.
- Latency:
  - Word accepted at edge k → first bit valid on s_out during cycle k+1.
  - Last bit valid during cycle k+N (k+N+1 with parity).
  - Steady-state throughput: one word per N cycles (N+1 with parity).
- Outputs: s_out, s_valid, busy and done are decoded only from registers, so they are glitch-free and have no input→output combinational path. load_ready depends only on state and cnt, not on load_valid.
- Reset mid-frame: the frame is abandoned immediately (asynchronously). No partial word is resumed after reset deasserts.
- Held input: load_valid held high continuously gives continuous back-to-back frames. p_in must be stable only on the accept edge.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - An even-parity bit (XOR of all N bits of p_in) is captured on accept and appended after the last payload bit.
  - The frame is N+1 bits; s_valid stays high for the parity bit.
  - done pulses with the parity bit, not with payload bit N-1.
- When undefined: frames are exactly N bits, and no parity logic or extra register bit exists.

Test Plan:
- Reset:
  - Assert reset asynchronously mid-cycle → s_out, s_valid, busy and done go to 0 immediately.
  - After deassert, load_ready = 1.
- Single word, LSB-first:
  - N=4, accept p_in=4'b1011 at edge 0.
  - s_out = 1,1,0,1 on cycles 1-4, with s_valid high on cycles 1-4 and done only on cycle 4.
  - Cycle 5: s_valid = 0, s_out = 0.
- Back-to-back:
  - Hold load_valid high with words 4'hA then 4'h5.
  - The 8 s_out bits 0,1,0,1,1,0,1,0 are contiguous, with load_ready high only on cycles 4 and 8.
- MSB_FIRST=1:
  - Accept 4'b1000 → s_out = 1,0,0,0.
  - Chained into the downstream 4-bit SISO stage, its s_out reproduces the stream 4 cycles later.
- Reset mid-frame:
  - Reset asserted on cycle 2 of word 4'hF.
  - After deassert: no further s_valid until a new accept, and a new word 4'h3 then serializes correctly as 1,1,0,0.
- PISO_PARITY_EN:
  - Accept 4'b0111 → s_out = 1,1,1,0,1 over 5 cycles, with done on cycle 5.
  - Accept 4'b0011 → parity bit 0.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding a downstream SISO stage over a valid/ready load handshake.
// Optional PISO_PARITY_EN appends an even-parity bit after the payload of every frame.
module piso_serializer #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] p_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         s_out,
    output logic         s_valid,
    output logic         busy,
    output logic         done
);

`ifdef PISO_PARITY_EN
    localparam int W = N + 1;
`else
    localparam int W = N;
`endif
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   shreg_reg, shreg_next;
    logic [CW-1:0]  cnt_reg, cnt_next;

    logic [W-1:0]   load_word;
    logic [W-1:0]   shifted;
    logic           out_bit;
    logic           last_bit;
    logic           accept;

    // The output end of shreg is bit 0 for LSB-first, bit W-1 for MSB-first;
    // the parity bit sits at the far end so it leaves after the payload.
    generate
        if (MSB_FIRST) begin : g_msb
`ifdef PISO_PARITY_EN
            assign load_word = {p_in, ^p_in};
`else
            assign load_word = p_in;
`endif
            assign shifted = {shreg_reg[W-2:0], 1'b0};
            assign out_bit = shreg_reg[W-1];
        end else begin : g_lsb
`ifdef PISO_PARITY_EN
            assign load_word = {^p_in, p_in};
`else
            assign load_word = p_in;
`endif
            assign shifted = {1'b0, shreg_reg[W-1:1]};
            assign out_bit = shreg_reg[0];
        end
    endgenerate

    assign last_bit   = (state_reg == SHIFT) && (cnt_reg == '0);
    assign load_ready = (state_reg == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    shreg_next = load_word;
                    cnt_next   = CNT_LOAD;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    // Reload on the last-bit edge keeps the stream gapless.
                    shreg_next = load_word;
                    cnt_next   = CNT_LOAD;
                end else if (last_bit) begin
                    shreg_next = shifted;
                    state_next = IDLE;
                end else begin
                    shreg_next = shifted;
                    cnt_next   = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign busy    = (state_reg == SHIFT);
    assign s_valid = busy;
    assign s_out   = busy & out_bit;
    assign done    = last_bit;

endmodule
